// File: rtl/io_input_sampler.sv
// io_input_sampler
//   Front end of the memory-mapped input port. Raw pins pass through a
//   two-flop synchroniser and a whole-word debounce filter; each newly
//   accepted stable value is presented on io_out with a one-cycle write
//   strobe. Sticky changed / change_mask / overrun flags are cleared by ack.
// Ports:
//   clock, reset       rising-edge clock, async active-high reset
//   pins_in[WIDTH]     raw asynchronous pins
//   enable             1 = filter/update active, 0 = hold
//   ack                clears changed, change_mask, overrun
//   io_out[WIDTH]      last accepted stable value
//   write              one-cycle strobe on each io_out update
//   changed            sticky: update since last ack
//   change_mask[WIDTH] sticky OR of toggled bits since last ack
//   overrun            sticky: update while changed was already pending

// Per-bit two-flop synchroniser cell.
module io_input_sampler_sync_bit (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic sync1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      q     <= 1'b0;
    end else begin
      sync1 <= d;
      q     <= sync1;
    end
  end
endmodule

module io_input_sampler #(
  parameter int WIDTH           = 32,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] pins_in,
  input  logic             enable,
  input  logic             ack,
  output logic [WIDTH-1:0] io_out,
  output logic             write,
  output logic             changed,
  output logic [WIDTH-1:0] change_mask,
  output logic             overrun
);
  localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] candidate;
  logic [CW-1:0]    count;
  logic             stable;
  logic             accept;

  // Synchroniser runs every edge regardless of enable.
  for (genvar i = 0; i < WIDTH; i++) begin : g_sync
    io_input_sampler_sync_bit u_sync (
      .clock (clock),
      .reset (reset),
      .d     (pins_in[i]),
      .q     (sync2[i])
    );
  end

  assign stable = (sync2 == candidate);
  // count stays saturated after an accept, but io_out == candidate then,
  // so the same value can never be re-strobed.
  assign accept = enable && stable && (count == CNT_MAX) && (candidate != io_out);

  // Debounce: any difference in the word restarts the count, so staggered
  // multi-bit changes collapse into one update once the word settles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      candidate <= '0;
      count     <= '0;
    end else if (!enable) begin
      candidate <= sync2;
      count     <= '0;
    end else if (!stable) begin
      candidate <= sync2;
      count     <= '0;
    end else if (count < CNT_MAX) begin
      count <= count + CW'(1);
    end
  end

  // Output and sticky status. An accept in the same cycle as ack wins:
  // the flags restart from the cleared state with just the new update.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      io_out      <= '0;
      write       <= 1'b0;
      changed     <= 1'b0;
      change_mask <= '0;
      overrun     <= 1'b0;
    end else begin
      write <= accept;
      if (accept) begin
        io_out      <= candidate;
        changed     <= 1'b1;
        change_mask <= (ack ? '0 : change_mask) | (io_out ^ candidate);
        overrun     <= (changed && !ack) || (overrun && !ack);
      end else if (ack) begin
        changed     <= 1'b0;
        change_mask <= '0;
        overrun     <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_io_input_sampler.sv
module tb_io_input_sampler;
  localparam int W = 32;
  localparam int D = 4;

  logic         clock;
  logic         reset;
  logic [W-1:0] pins_in;
  logic         enable;
  logic         ack;
  logic [W-1:0] io_out;
  logic         write;
  logic         changed;
  logic [W-1:0] change_mask;
  logic         overrun;

  typedef struct {
    logic [W-1:0] io;
    logic [W-1:0] mask;
    logic         ch;
    logic         ov;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  io_input_sampler #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clock       (clock),
    .reset       (reset),
    .pins_in     (pins_in),
    .enable      (enable),
    .ack         (ack),
    .io_out      (io_out),
    .write       (write),
    .changed     (changed),
    .change_mask (change_mask),
    .overrun     (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Scoreboard monitor: every write strobe must match the oldest expectation.
  always @(negedge clock) begin
    if (write === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write io_out=%h", io_out);
      end else begin
        mon_e = sb.pop_front();
        if ({io_out, change_mask, changed, overrun} !== {mon_e.io, mon_e.mask, mon_e.ch, mon_e.ov}) begin
          errors++;
          $display("FAIL update io=%h mask=%h ch=%b ov=%b expected io=%h mask=%h ch=%b ov=%b",
                   io_out, change_mask, changed, overrun, mon_e.io, mon_e.mask, mon_e.ch, mon_e.ov);
        end
      end
    end
  end

  function automatic exp_t mk(input logic [W-1:0] io, input logic [W-1:0] mask,
                              input logic ch, input logic ov);
    exp_t e;
    e.io = io; e.mask = mask; e.ch = ch; e.ov = ov;
    return e;
  endfunction

  // Bounded wait: lat = negedge index of first write (-1 if none).
  task automatic wait_write(input int max_cyc, output int lat, output int pulses);
    lat = -1;
    pulses = 0;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clock);
      if (write === 1'b1) begin
        pulses++;
        if (lat < 0) lat = i;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; pins_in = '0; enable = 1'b1; ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++;
      if ({io_out, change_mask, changed, overrun, write} !== '0) begin
        errors++;
        $display("FAIL reset_state io=%h mask=%h ch=%b ov=%b wr=%b expected all 0",
                 io_out, change_mask, changed, overrun, write);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_clean_update();
    int lat, pulses;
    @(negedge clock);
    pins_in = 32'h0000_00A5;
    sb.push_back(mk(32'hA5, 32'hA5, 1'b1, 1'b0));
    wait_write(14, lat, pulses);
    checks++;
    if (lat !== 8) begin
      errors++; $display("FAIL clean_latency got=%0d expected=8", lat);
    end
    checks++;
    if (pulses !== 1) begin
      errors++; $display("FAIL clean_pulse_count got=%0d expected=1", pulses);
    end
  endtask

  task automatic test_glitch();
    int lat, pulses;
    @(negedge clock);
    pins_in = 32'h0000_00AD;
    repeat (3) @(negedge clock);
    pins_in = 32'h0000_00A5;
    wait_write(15, lat, pulses);
    checks++;
    if (pulses !== 0) begin
      errors++; $display("FAIL glitch_write got=%0d expected=0", pulses);
    end
    checks++;
    if (io_out !== 32'hA5) begin
      errors++; $display("FAIL glitch_io_out got=%h expected=a5", io_out);
    end
  endtask

  task automatic test_overrun();
    int lat, pulses;
    @(negedge clock);
    pins_in = 32'h0000_00A4;
    sb.push_back(mk(32'hA4, 32'hA5, 1'b1, 1'b1));
    wait_write(14, lat, pulses);
    checks++;
    if (lat !== 8) begin
      errors++; $display("FAIL overrun_latency got=%0d expected=8", lat);
    end
  endtask

  task automatic test_ack_same_cycle();
    int lat;
    lat = -1;
    @(negedge clock);
    pins_in = 32'h0000_00F0;
    sb.push_back(mk(32'hF0, 32'h54, 1'b1, 1'b0));
    for (int i = 1; i <= 14; i++) begin
      @(negedge clock);
      if (write === 1'b1 && lat < 0) lat = i;
      ack = (i == 7);
    end
    checks++;
    if (lat !== 8) begin
      errors++; $display("FAIL ack_same_latency got=%0d expected=8", lat);
    end
  endtask

  task automatic test_ack_clear();
    @(negedge clock);
    ack = 1'b1;
    @(negedge clock);
    ack = 1'b0;
    checks++;
    if ({changed, change_mask, overrun} !== '0) begin
      errors++;
      $display("FAIL ack_clear ch=%b mask=%h ov=%b expected 0", changed, change_mask, overrun);
    end
    checks++;
    if (io_out !== 32'hF0) begin
      errors++; $display("FAIL ack_clear_io got=%h expected=f0", io_out);
    end
  endtask

  task automatic test_enable_mid_count();
    int lat, pulses;
    @(negedge clock);
    pins_in = 32'h0000_000F;
    repeat (5) @(negedge clock);   // count == 2 here
    enable = 1'b0;
    wait_write(6, lat, pulses);
    checks++;
    if (pulses !== 0) begin
      errors++; $display("FAIL enable_hold_write got=%0d expected=0", pulses);
    end
    enable = 1'b1;
    sb.push_back(mk(32'h0F, 32'hFF, 1'b1, 1'b0));
    wait_write(10, lat, pulses);
    checks++;
    if (lat !== D + 1) begin
      errors++; $display("FAIL reenable_latency got=%0d expected=%0d", lat, D + 1);
    end
  endtask

  task automatic test_reset_mid_count();
    int lat, pulses;
    @(negedge clock);
    pins_in = 32'h0000_003C;
    repeat (6) @(negedge clock);   // count == 3 here
    #2 reset = 1'b1;
    #1;                            // still well before the next rising edge
    checks++;
    if ({io_out, change_mask, changed, overrun, write} !== '0) begin
      errors++;
      $display("FAIL async_reset io=%h mask=%h ch=%b ov=%b wr=%b expected all 0",
               io_out, change_mask, changed, overrun, write);
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    sb.push_back(mk(32'h3C, 32'h3C, 1'b1, 1'b0));
    wait_write(14, lat, pulses);
    checks++;
    if (lat !== 8) begin
      errors++; $display("FAIL post_reset_latency got=%0d expected=8", lat);
    end
  endtask

  initial begin
    test_reset();
    test_clean_update();
    test_glitch();
    test_overrun();
    test_ack_same_cycle();
    test_ack_clear();
    test_enable_mid_count();
    test_reset_mid_count();
    repeat (2) @(negedge clock);
    checks++;
    if (sb.size() !== 0) begin
      errors++; $display("FAIL pending_updates got=%0d expected=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
